hc4_boot_ctrl: RTL

HC4_BOOT_CTRL -- requirements
Module: hc4_boot_ctrl

---
 rtl/hc4_boot_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/hc4_boot_ctrl.sv
`timescale 1ns/1ps
// hc4_boot_ctrl: boot loader and debug controller for the HC4 core.
// Receives a length-prefixed program image over a valid/ready byte stream and
// writes it to program memory. It then holds the core in reset for a fixed
// number of cycles and parks it in HALT. From HALT the core can be single-stepped
// or run, with a PC breakpoint available.
module hc4_boot_ctrl #(
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        load_req,
  input  logic        bp_en,
  input  logic [11:0] bp_addr,
  input  logic [11:0] pc_in,
  output logic        cpu_nreset,
  output logic        cpu_en,
  output logic        halted,
  output logic        bp_hit,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LOAD   = 3'd2,
    S_RSTC   = 3'd3,
    S_HALT   = 3'd4,
    S_RUN    = 3'd5,
    S_STEP   = 3'd6
  } state_t;

  // Reset hold counter is loaded with RST_CYCLES-1 and leaves RSTC on zero.
  localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [11:0] len_reg;
  logic [11:0] addr_cnt_reg;
  logic [3:0]  rst_cnt_reg;
  logic        mem_we_reg;
  logic [11:0] mem_addr_reg;
  logic [7:0]  mem_wdata_reg;
  logic        bp_hit_reg;
  logic        first_run_reg;  // first RUN cycle after HALT: breakpoint masked
  logic        bp_match;
  logic        bp_stop;

  // Breakpoint compare, masked on the first RUN cycle so a run resumed at the
  // breakpoint PC can execute that instruction.
  assign bp_match = bp_en && (pc_in == bp_addr) && !first_run_reg;

  // Next-state decode and Moore/Mealy outputs of the control FSM.
  always_comb begin
    state_next = state_reg;
    ld_ready   = 1'b0;
    cpu_nreset = 1'b0;
    cpu_en     = 1'b0;
    halted     = 1'b0;
    bp_stop    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        ld_ready = 1'b1;
        if (ld_valid) state_next = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && (addr_cnt_reg == len_reg)) state_next = S_RSTC;
      end
      S_RSTC: begin
        cpu_en = 1'b1;
        if (rst_cnt_reg == 4'd0) state_next = S_HALT;
      end
      S_HALT: begin
        cpu_nreset = 1'b1;
        halted     = 1'b1;
        if (load_req)      state_next = S_IDLE;
        else if (run_req)  state_next = S_RUN;
        else if (step_req) state_next = S_STEP;
      end
      S_RUN: begin
        cpu_nreset = 1'b1;
        cpu_en     = ~(halt_req | load_req | bp_match);
        if (load_req)      state_next = S_IDLE;
        else if (halt_req) state_next = S_HALT;
        else if (bp_match) begin
          state_next = S_HALT;
          bp_stop    = 1'b1;
        end
      end
      S_STEP: begin
        cpu_nreset = 1'b1;
        cpu_en     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Frame length capture, write address counter, memory write port,
  // reset-hold counter and breakpoint bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg       <= '0;
      addr_cnt_reg  <= '0;
      rst_cnt_reg   <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      bp_hit_reg    <= 1'b0;
      first_run_reg <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (state_reg == S_IDLE && ld_valid) begin
        len_reg[11:8] <= ld_data[3:0];
      end
      if (state_reg == S_LEN_LO && ld_valid) begin
        len_reg[7:0] <= ld_data;
        addr_cnt_reg <= '0;
      end
      if (state_reg == S_LOAD && ld_valid) begin
        mem_we_reg    <= 1'b1;
        mem_addr_reg  <= addr_cnt_reg;
        mem_wdata_reg <= ld_data;
        addr_cnt_reg  <= addr_cnt_reg + 12'd1;
      end
      if (state_next == S_RSTC && state_reg != S_RSTC) begin
        rst_cnt_reg <= RST_LOAD;
      end else if (state_reg == S_RSTC && rst_cnt_reg != 4'd0) begin
        rst_cnt_reg <= rst_cnt_reg - 4'd1;
      end
      bp_hit_reg    <= bp_stop;
      first_run_reg <= (state_reg == S_HALT) && (state_next == S_RUN);
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign bp_hit    = bp_hit_reg;
  assign state     = state_reg;

endmodule
